// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data-side RAM plus keypad FIFO, display and cycle-counter MMIO window
module dmem_mmio #(
    parameter int DEPTH_WORDS = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [31:0] display_out,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0] ram [DEPTH_WORDS];
    logic [3:0]  fifo_mem [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   display_q, display_d;
    logic [31:0]   cycles_q, cycles_d;
    logic          addr_err_q, addr_err_d;

    logic [29:0]   waddr;
    logic [AW-1:0] ram_idx;
    logic          sel_ram, sel_kdata, sel_kstat, sel_disp, sel_cyc, sel_mapped;
    logic          access, pop_req, pop_ok, push_ok, fifo_empty, fifo_full;
    logic [31:0]   count_ext;
    logic [2:0]    cnt_field;
    logic          unused_ok;

    assign unused_ok = &{1'b0, ALUResult[1:0]};

    assign waddr      = ALUResult[31:2];
    assign ram_idx    = ALUResult[AW+1:2];
    assign sel_ram    = (ALUResult[31:8] == 24'h0);
    assign sel_kdata  = (waddr == 30'h40);
    assign sel_kstat  = (waddr == 30'h41);
    assign sel_disp   = (waddr == 30'h42);
    assign sel_cyc    = (waddr == 30'h43);
    assign sel_mapped = sel_ram | sel_kdata | sel_kstat | sel_disp | sel_cyc;

    // Non-memory instructions also drive ALUResult, so every side effect needs a strobe.
    assign access     = MemWrite | MemRead;
    assign pop_req    = MemRead & ~MemWrite & sel_kdata;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop_ok     = pop_req & ~fifo_empty;
    assign push_ok    = key_valid & (~fifo_full | pop_ok);

    assign count_ext  = 32'(count_q);
    assign cnt_field  = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];

    always_comb begin
        ReadData = 32'h0;
        if (sel_ram) begin
            ReadData = ram[ram_idx];
        end else if (sel_kdata) begin
            ReadData = fifo_empty ? 32'h0 : {28'h0, fifo_mem[rd_ptr_q]};
        end else if (sel_kstat) begin
            ReadData = {27'h0, ovf_q, cnt_field, ~fifo_empty};
        end else if (sel_disp) begin
            ReadData = display_q;
        end else if (sel_cyc) begin
            ReadData = cycles_q;
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        display_d  = display_q;
        cycles_d   = cycles_q + 32'd1;
        addr_err_d = access & ~sel_mapped;

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (MemWrite) begin
            if (sel_kstat && WriteData[4]) begin
                ovf_d = 1'b0;
            end
            if (sel_disp) begin
                display_d = WriteData;
            end
            if (sel_cyc) begin
                cycles_d = 32'h0;
            end
        end
        // A fresh drop in the same cycle as a clear leaves the sticky bit set.
        if (key_valid && fifo_full && !pop_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            display_q  <= 32'h0;
            cycles_q   <= 32'h0;
            addr_err_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            display_q  <= display_d;
            cycles_q   <= cycles_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (MemWrite && sel_ram) begin
            ram[ram_idx] <= WriteData;
        end
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= key_code;
        end
    end

    assign display_out = display_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - directed table plus randomized checks of dmem_mmio against a queue-based model
module tb_dmem_mmio;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] display_out;
    logic        addr_err;

    dmem_mmio #(.DEPTH_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .ALUResult(ALUResult), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
        .key_valid(key_valid), .key_code(key_code),
        .display_out(display_out), .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    int unsigned m_q[$];
    logic [31:0] m_ram [64];
    bit          m_ram_ok [64];
    bit          m_ovf;
    logic [31:0] m_disp;
    logic [31:0] m_cyc;
    bit          m_err;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        kv;
        logic [3:0]  kc;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_disp = 32'h0;
        m_cyc  = 32'h0;
        m_err  = 1'b0;
    endfunction

    function automatic logic [31:0] status_val();
        int unsigned cnt;
        int unsigned field;
        cnt   = m_q.size();
        field = (cnt > 7) ? 7 : cnt;
        return 32'((m_ovf ? 16 : 0) + field * 2 + ((cnt != 0) ? 1 : 0));
    endfunction

    function automatic void model_read(input logic [31:0] addr, output logic [31:0] val, output bit known);
        int idx;
        known = 1'b1;
        val   = 32'h0;
        if (addr < 32'd256) begin
            idx   = int'(addr[7:2]) % 64;
            known = m_ram_ok[idx];
            val   = m_ram[idx];
        end else if (addr[31:4] == 28'h10) begin
            case (addr[3:2])
                2'd0: val = (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0;
                2'd1: val = status_val();
                2'd2: val = m_disp;
                default: val = m_cyc;
            endcase
        end
    endfunction

    function automatic void model_edge(input logic we, input logic re, input logic [31:0] addr,
                                       input logic [31:0] wd, input logic kv, input logic [3:0] kc);
        bit is_ram;
        bit is_mmio;
        is_ram  = (addr < 32'd256);
        is_mmio = (addr[31:4] == 28'h10);
        if (we && is_ram) begin
            m_ram[int'(addr[7:2]) % 64]    = wd;
            m_ram_ok[int'(addr[7:2]) % 64] = 1'b1;
        end
        if (we && is_mmio && addr[3:2] == 2'd1 && wd[4]) m_ovf = 1'b0;
        if (we && is_mmio && addr[3:2] == 2'd2) m_disp = wd;
        if (we && is_mmio && addr[3:2] == 2'd3) m_cyc = 32'h0;
        else m_cyc = m_cyc + 32'd1;
        if (re && !we && is_mmio && addr[3:2] == 2'd0 && m_q.size() > 0) void'(m_q.pop_front());
        if (kv) begin
            if (m_q.size() < 4) m_q.push_back(int'(kc));
            else m_ovf = 1'b1;
        end
        m_err = (we || re) && !is_ram && !is_mmio;
    endfunction

    // Called just after a rising edge; drives one access cycle and leaves time just after the next edge.
    task automatic step(input vec_t v, input string nm);
        logic [31:0] mexp;
        bit          mknown;
        MemWrite  = v.we;
        MemRead   = v.re;
        ALUResult = v.addr;
        WriteData = v.wd;
        key_valid = v.kv;
        key_code  = v.kc;
        model_read(v.addr, mexp, mknown);
        #2;
        if (v.chk) check({nm, "_rd"}, ReadData, v.exp);
        if (mknown) check({nm, "_model_rd"}, ReadData, mexp);
        @(posedge clk);
        model_edge(v.we, v.re, v.addr, v.wd, v.kv, v.kc);
        #1;
        check({nm, "_addr_err"}, {31'h0, addr_err}, {31'h0, m_err});
        check({nm, "_display"}, display_out, m_disp);
    endtask

    function automatic void add(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wd,
                                input logic kv, input logic [3:0] kc, input logic chk, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wd = wd;
        v.kv = kv; v.kc = kc; v.chk = chk; v.exp = exp;
        vt.push_back(v);
    endfunction

    initial begin
        vec_t v;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        ALUResult = 32'h104;
        WriteData = 32'h0;
        key_valid = 1'b1;
        key_code  = 4'h5;
        model_reset();
        for (int i = 0; i < 64; i++) m_ram_ok[i] = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check("reset_status", ReadData, 32'h0);
        check("reset_display", display_out, 32'h0);
        check("reset_addr_err", {31'h0, addr_err}, 32'h0);
        ALUResult = 32'h10C;
        #1;
        check("reset_cycles", ReadData, 32'h0);
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        add(0, 1, 32'h10C, 0,            0, 0, 1, 32'h0);
        add(1, 0, 32'h004, 32'hAABBCCDD, 0, 0, 0, 32'h0);
        add(0, 1, 32'h004, 0,            0, 0, 1, 32'hAABBCCDD);
        add(0, 1, 32'h006, 0,            0, 0, 1, 32'hAABBCCDD);
        add(0, 0, 32'h000, 0,            1, 3, 0, 32'h0);
        add(0, 0, 32'h000, 0,            1, 7, 0, 32'h0);
        add(0, 1, 32'h104, 0,            0, 0, 1, 32'h5);
        add(0, 1, 32'h100, 0,            0, 0, 1, 32'h3);
        add(0, 1, 32'h100, 0,            0, 0, 1, 32'h7);
        add(0, 1, 32'h100, 0,            0, 0, 1, 32'h0);
        add(0, 1, 32'h104, 0,            0, 0, 1, 32'h0);
        for (int k = 1; k <= 5; k++) add(0, 0, 32'h0, 0, 1, 4'(k), 0, 32'h0);
        add(0, 1, 32'h104, 0,            0, 0, 1, 32'h19);
        add(1, 0, 32'h104, 32'h10,       0, 0, 0, 32'h0);
        add(0, 1, 32'h104, 0,            0, 0, 1, 32'h9);
        add(0, 1, 32'h100, 0,            1, 9, 1, 32'h1);
        add(0, 1, 32'h104, 0,            0, 0, 1, 32'h9);
        add(0, 1, 32'h100, 0,            0, 0, 1, 32'h2);
        add(0, 1, 32'h100, 0,            0, 0, 1, 32'h3);
        add(0, 1, 32'h100, 0,            0, 0, 1, 32'h4);
        add(0, 1, 32'h100, 0,            0, 0, 1, 32'h9);
        add(0, 1, 32'h104, 0,            0, 0, 1, 32'h0);
        add(0, 0, 32'h000, 0,            1, 6, 0, 32'h0);
        add(0, 0, 32'h100, 0,            0, 0, 0, 32'h0);
        add(0, 1, 32'h104, 0,            0, 0, 1, 32'h3);
        add(1, 0, 32'h200, 32'hDEAD,     0, 0, 0, 32'h0);
        add(0, 0, 32'h200, 0,            0, 0, 1, 32'h0);
        add(0, 1, 32'h200, 0,            0, 0, 1, 32'h0);
        add(0, 1, 32'h104, 0,            0, 0, 1, 32'h3);
        add(1, 0, 32'h108, 32'h12345678, 0, 0, 0, 32'h0);
        add(0, 1, 32'h108, 0,            0, 0, 1, 32'h12345678);
        add(1, 1, 32'h004, 32'h11111111, 0, 0, 1, 32'hAABBCCDD);
        add(0, 1, 32'h004, 0,            0, 0, 1, 32'h11111111);
        add(1, 1, 32'h100, 32'h0,        0, 0, 1, 32'h6);
        add(0, 1, 32'h104, 0,            0, 0, 1, 32'h3);
        add(1, 0, 32'h10C, 32'h5,        0, 0, 0, 32'h0);
        add(0, 1, 32'h10C, 0,            0, 0, 1, 32'h0);
        add(0, 1, 32'h10C, 0,            0, 0, 1, 32'h1);

        for (int i = 0; i < vt.size(); i++) step(vt[i], $sformatf("vec%0d", i));

        ALUResult = 32'h104;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        key_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_display", display_out, 32'h0);
        check("async_status", ReadData, 32'h0);
        check("async_addr_err", {31'h0, addr_err}, 32'h0);
        #1;
        reset = 1'b1;
        model_reset();

        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: v.addr = 32'($urandom_range(0, 255));
                4: v.addr = 32'h100;
                5: v.addr = 32'h104;
                6: v.addr = 32'h108;
                7: v.addr = 32'h10C;
                8: v.addr = 32'h200 | 32'($urandom_range(0, 255));
                default: v.addr = $urandom;
            endcase
            v.we  = ($urandom_range(0, 3) == 0);
            v.re  = ($urandom_range(0, 1) == 0);
            v.wd  = $urandom;
            v.kv  = ($urandom_range(0, 2) == 0);
            v.kc  = 4'($urandom_range(0, 15));
            v.chk = 1'b0;
            v.exp = 32'h0;
            step(v, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the single-cycle ARM core. It sits on the core's data port (address = ALUResult, WriteData, MemWrite, ReadData) and serves word RAM plus a small memory-mapped I/O window. The window holds a keypad input FIFO, a display output register and a free-running cycle counter for the calculator firmware. Reads are combinational so that loads complete in the core's single cycle; every state change happens on the clock edge.

## Interface
- DEPTH_WORDS, 64: RAM size in 32-bit words, power of 2, ≤ 64 (fits 0x000–0x0FF).
- FIFO_DEPTH, 4: keypad FIFO entries, power of 2, ≥ 2.

- clk  in  1  rising-edge clock, shared with the core.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ALUResult  in  32  data address from the core.
- WriteData  in  32  store data.
- MemWrite  in  1  store strobe for the current cycle.
- MemRead  in  1  load strobe, driven from the decoder's MemtoReg; qualifies read side effects.
- ReadData  out  32  load data, combinational.
- key_valid  in  1  one-cycle push strobe from the keypad scanner (already synchronous to clk).
- key_code  in  4  key code pushed with key_valid.
- display_out  out  32  DISPLAY register contents.
- addr_err  out  1  registered one-cycle pulse on an access to an unmapped address.

## Operation
- Decode uses word address ALUResult[31:2]; ALUResult[1:0] are ignored.
- 0x000–0x0FF RAM: index ALUResult[7:2] mod DEPTH_WORDS, full read/write.
- 0x100 KEY_DATA (RO):
  - Reads return {28'b0, head code} when the FIFO is non-empty, else 0.
  - A read with MemRead=1 pops the FIFO at the edge.
- 0x104 KEY_STATUS:
  - Read value: bit0 = non-empty, bits[3:1] = count (0..FIFO_DEPTH, saturating field), bit4 = overflow sticky, others 0.
  - A write with WriteData[4]=1 clears overflow.
- 0x108 DISPLAY (RW): 32-bit register, drives display_out.
- 0x10C CYCLES: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0. Any write loads 0.
- Any other address: reads return 0, writes are ignored. A MemRead or MemWrite access pulses addr_err on the next cycle.
- Side effects (pop, write, addr_err) require MemRead or MemWrite. Address activity alone does nothing, since non-memory instructions also drive ALUResult.
- MemWrite=1 and MemRead=1 together: treated as a write. No pop.
- FIFO:
  - Push when key_valid=1 and not full.
  - key_valid while full, with no pop in the same cycle: the code is dropped and overflow is set.
  - Simultaneous push and pop when full: both happen, count unchanged, no overflow.
  - Simultaneous push and pop when empty: the push happens, and the pop is a no-op (the read returned 0).
  - Pop when empty: no state change.
- Reset values:
  - FIFO empty, overflow=0, display_out=0, CYCLES=0, addr_err=0.
  - RAM is not reset (contents undefined until written).
  - ReadData follows the reset state combinationally.
- Reset asserted mid-operation: all registers above clear immediately. Any in-flight write or pop is lost.

## Timing
- ReadData is valid in the same cycle as the address (zero latency, combinational). It reflects state before the coming edge.
- Writes and pops commit at the rising edge that ends the access cycle.
- A read and a write to the same address in the same cycle return the old value.
- A key pushed at edge N is readable from cycle N+1.
- addr_err goes high for exactly the cycle after the offending access.
- A CYCLES write at edge N gives a read value of 0 in cycle N+1 and 1 in cycle N+2.

## Test plan
- Reset then RAM: after reset deasserts, CYCLES reads 0 or 1. Store 0xAABBCCDD to 0x004, load 0x004 → 0xAABBCCDD. Load 0x006 → the same word (low bits ignored).
- FIFO order and pop: push codes 3, 7. KEY_STATUS=0x005. Load 0x100 → 3, then 7, then 0. KEY_STATUS=0x000.
- Overflow: push 5 codes with FIFO_DEPTH=4. KEY_STATUS=0x019, and the 5th code is lost. Store 0x10 to 0x104 → KEY_STATUS=0x009.
- Simultaneous push and pop when full: FIFO full with 1,2,3,4. Pop and push 9 in the same cycle → read returns 1, count stays 4, overflow 0, drain order 2,3,4,9.
- No false side effects: ALUResult=0x100 with MemRead=0 and MemWrite=0 → count unchanged. Store to 0x200 → addr_err pulses for one cycle and a load of 0x200 returns 0.
- Display and async reset: store 0x12345678 to 0x108 → display_out=0x12345678. Drop reset between edges → display_out=0 and the FIFO empties with no clock edge.
